// File: rtl/reservoir_pkg.sv
// Shared types and helpers for the reservoir sequencer.
// Latency: none (types and a combinational function only).
// Backpressure: not applicable.
package reservoir_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SUM   = 2'd1,
        REQ   = 2'd2,
        WRITE = 2'd3
    } state_t;

    // Widest operand the saturating adder supports; callers zero-extend into it.
    localparam int unsigned SAT_W = 64;

    // Unsigned add of a and b, clamped to 2^w - 1 (w <= SAT_W).
    function automatic logic [SAT_W-1:0] sat_add(
        input logic [SAT_W-1:0] a,
        input logic [SAT_W-1:0] b,
        input int unsigned      w
    );
        logic [SAT_W:0] s;
        logic [SAT_W:0] lim;
        s   = {1'b0, a} + {1'b0, b};
        lim = ({{SAT_W{1'b0}}, 1'b1} << w) - {{SAT_W{1'b0}}, 1'b1};
        if (s > lim) begin
            s = lim;
        end
        return s[SAT_W-1:0];
    endfunction

endpackage

// File: rtl/node_ring_buffer.sv
// Circular node store: combinational read and registered write at the same pointer.
// Latency: read is combinational; write and pointer advance take effect next cycle.
// Backpressure: none; the owner writes only when a new node is ready.
module node_ring_buffer #(
    parameter int unsigned DEPTH = 10,
    parameter int unsigned WIDTH = 32,
    parameter int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic [PTR_W-1:0] ptr
);

    logic [WIDTH-1:0] mem [DEPTH];

    // The slot under the pointer is the oldest node, i.e. the full-length delayed feedback.
    assign rd_data = mem[ptr];

    // Storage is cleared by reset directly, so the buffer is all-zero as soon as reset releases.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
            ptr <= '0;
        end else if (wr_en) begin
            mem[ptr] <= wr_data;
            ptr      <= (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
        end
    end

endmodule

// File: rtl/reservoir_seq.sv
// Delay-line reservoir: node = NL((din >> IN_SHIFT) + (oldest_node >> FB_SHIFT)).
// Latency: bypass accept->dout_valid 2 cycles; external path dout_valid 1 cycle after nl_ack.
// Backpressure: din_ready low while a sample is in flight; nl_req held until ack or timeout.
module reservoir_seq #(
    parameter int unsigned VIRTUAL_NODES  = 10,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned NL_WIDTH       = 12,
    parameter int unsigned IN_SHIFT       = 0,
    parameter int unsigned FB_SHIFT       = 1,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             bypass,
    input  logic                             din_valid,
    output logic                             din_ready,
    input  logic [DATA_WIDTH-1:0]            din,
    output logic                             nl_req,
    output logic [NL_WIDTH-1:0]              nl_data_out,
    input  logic                             nl_ack,
    input  logic [NL_WIDTH-1:0]              nl_data_in,
    output logic                             dout_valid,
    output logic [DATA_WIDTH-1:0]            dout,
    output logic [$clog2(VIRTUAL_NODES)-1:0] node_idx,
    output logic                             timeout_err
);
    import reservoir_pkg::*;

    localparam int unsigned PTR_W = $clog2(VIRTUAL_NODES);
    localparam int unsigned TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned LOW_W = DATA_WIDTH - NL_WIDTH;

    state_t                state;
    logic [DATA_WIDTH-1:0] din_q;
    logic [DATA_WIDTH-1:0] fb_q;
    logic                  byp_q;
    logic [TO_W-1:0]       wait_cnt;
    logic [DATA_WIDTH-1:0] fb_rd;
    logic [PTR_W-1:0]      wr_ptr;
    logic [NL_WIDTH-1:0]   sum_msb;
    logic                  wr_en;

    // Nonlinearity result sits in the node MSBs with the low bits zeroed.
    function automatic logic [DATA_WIDTH-1:0] place(input logic [NL_WIDTH-1:0] r);
        return DATA_WIDTH'(r) << LOW_W;
    endfunction

    // Top NL_WIDTH bits of the saturated sum feed both the DAC and the digital bypass.
    assign sum_msb = NL_WIDTH'(sat_add(SAT_W'(din_q >> IN_SHIFT),
                                       SAT_W'(fb_q >> FB_SHIFT),
                                       DATA_WIDTH) >> LOW_W);

    // dout already holds the new node value during WRITE, so it doubles as the write data.
    assign wr_en = (state == WRITE);

    node_ring_buffer #(
        .DEPTH (VIRTUAL_NODES),
        .WIDTH (DATA_WIDTH),
        .PTR_W (PTR_W)
    ) u_ring (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (dout),
        .rd_data (fb_rd),
        .ptr     (wr_ptr)
    );

    // Sequencer: capture, sum, optional external nonlinearity handshake, write-back.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            din_q       <= '0;
            fb_q        <= '0;
            byp_q       <= 1'b0;
            wait_cnt    <= '0;
            din_ready   <= 1'b0;
            nl_req      <= 1'b0;
            nl_data_out <= '0;
            dout_valid  <= 1'b0;
            dout        <= '0;
            node_idx    <= '0;
            timeout_err <= 1'b0;
        end else begin
            dout_valid  <= 1'b0;
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    // din_ready is held low for the first cycle after reset release.
                    din_ready <= 1'b1;
                    if (din_valid && din_ready) begin
                        din_q     <= din;
                        fb_q      <= fb_rd;
                        byp_q     <= bypass;
                        din_ready <= 1'b0;
                        state     <= SUM;
                    end
                end
                SUM: begin
                    if (byp_q) begin
                        dout       <= place(sum_msb);
                        node_idx   <= wr_ptr;
                        dout_valid <= 1'b1;
                        state      <= WRITE;
                    end else begin
                        nl_req      <= 1'b1;
                        nl_data_out <= sum_msb;
                        wait_cnt    <= '0;
                        state       <= REQ;
                    end
                end
                REQ: begin
                    // An ack in the expiry cycle still wins over the timeout.
                    if (nl_ack) begin
                        nl_req     <= 1'b0;
                        dout       <= place(nl_data_in);
                        node_idx   <= wr_ptr;
                        dout_valid <= 1'b1;
                        state      <= WRITE;
                    end else if (wait_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        nl_req      <= 1'b0;
                        dout        <= '0;
                        node_idx    <= wr_ptr;
                        dout_valid  <= 1'b1;
                        timeout_err <= 1'b1;
                        state       <= WRITE;
                    end else begin
                        wait_cnt <= wait_cnt + TO_W'(1);
                    end
                end
                WRITE: begin
                    din_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reservoir_seq.sv
// Directed bench for reservoir_seq with a queue scoreboard checked by a dout monitor.
// Latency: checks bypass 2-cycle and external ack+1 timing explicitly.
// Backpressure: checks din_ready stays low while a sample is in flight.
module tb_reservoir_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        bypass;
    logic        din_valid;
    logic        din_ready;
    logic [31:0] din;
    logic        nl_req;
    logic [11:0] nl_data_out;
    logic        nl_ack;
    logic [11:0] nl_data_in;
    logic        dout_valid;
    logic [31:0] dout;
    logic [1:0]  node_idx;
    logic        timeout_err;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [31:0] dout;
        logic [1:0]  idx;
        logic        err;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    reservoir_seq #(
        .VIRTUAL_NODES  (4),
        .DATA_WIDTH     (32),
        .NL_WIDTH       (12),
        .IN_SHIFT       (0),
        .FB_SHIFT       (1),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bypass      (bypass),
        .din_valid   (din_valid),
        .din_ready   (din_ready),
        .din         (din),
        .nl_req      (nl_req),
        .nl_data_out (nl_data_out),
        .nl_ack      (nl_ack),
        .nl_data_in  (nl_data_in),
        .dout_valid  (dout_valid),
        .dout        (dout),
        .node_idx    (node_idx),
        .timeout_err (timeout_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every dout_valid pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst === 1'b1 && dout_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_dout_valid", 32'(dout_valid), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("dout", dout, e.dout);
                chk("node_idx", 32'(node_idx), 32'(e.idx));
                chk("timeout_err", 32'(timeout_err), 32'(e.err));
            end
        end
        if (rst === 1'b1 && timeout_err === 1'b1 && dout_valid !== 1'b1) begin
            chk("timeout_err_without_dout", 32'(dout_valid), 32'd1);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, tests=%0d", tests);
        $fatal(1, "watchdog expired");
    end

    task automatic accept(input logic [31:0] d, input logic byp);
        int n = 0;
        @(negedge clk);
        while (din_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("din_ready_before_accept", 32'(din_ready), 32'd1);
        bypass    = byp;
        din       = d;
        din_valid = 1'b1;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        din       = 32'hDEAD_BEEF;
    endtask

    // Bypass sample; bypass is flipped right after capture and must have no effect.
    task automatic byp_sample(input logic [31:0] d, input logic [31:0] exp_dout, input logic [1:0] exp_idx);
        sb.push_back({exp_dout, exp_idx, 1'b0});
        accept(d, 1'b1);
        bypass = 1'b0;
        @(negedge clk);
        chk("byp_dout_valid_n1", 32'(dout_valid), 32'd0);
        chk("byp_din_ready_n1", 32'(din_ready), 32'd0);
        chk("byp_no_nl_req", 32'(nl_req), 32'd0);
        @(negedge clk);
        chk("byp_dout_valid_n2", 32'(dout_valid), 32'd1);
        @(negedge clk);
        chk("byp_din_ready_n3", 32'(din_ready), 32'd1);
    endtask

    // External sample; ack_cyc is the REQ cycle (1-based) carrying nl_ack, 0 = never.
    task automatic ext_sample(input logic [31:0] d, input logic [11:0] exp_nl, input int ack_cyc,
                              input logic [11:0] ack_dat, input logic [31:0] exp_dout,
                              input logic [1:0] exp_idx, input logic exp_err);
        int n = 0;
        int req_cycles = 1;
        sb.push_back({exp_dout, exp_idx, exp_err});
        accept(d, 1'b0);
        bypass = 1'b1;
        @(negedge clk);
        while (nl_req !== 1'b1 && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk("nl_req_rise", 32'(nl_req), 32'd1);
        chk("nl_data_out", 32'(nl_data_out), 32'(exp_nl));
        while (nl_req === 1'b1 && req_cycles < 40) begin
            chk("din_ready_in_req", 32'(din_ready), 32'd0);
            if (req_cycles == ack_cyc) begin
                nl_ack     = 1'b1;
                nl_data_in = ack_dat;
            end
            @(posedge clk);
            #1;
            nl_ack     = 1'b0;
            nl_data_in = 12'h000;
            @(negedge clk);
            if (nl_req === 1'b1) begin
                req_cycles++;
                chk("nl_data_out_held", 32'(nl_data_out), 32'(exp_nl));
            end
        end
        chk("req_cycles", 32'(req_cycles), (ack_cyc > 0) ? 32'(ack_cyc) : 32'd16);
        chk("dout_valid_after_req", 32'(dout_valid), 32'd1);
        // An ack during WRITE (outside REQ) must be ignored.
        nl_ack     = 1'b1;
        nl_data_in = 12'hFFF;
        @(posedge clk);
        #1;
        nl_ack = 1'b0;
    endtask

    initial begin
        int n;
        rst        = 1'b0;
        bypass     = 1'b0;
        din_valid  = 1'b0;
        din        = '0;
        nl_ack     = 1'b0;
        nl_data_in = '0;

        repeat (3) @(negedge clk);
        chk("reset_din_ready", 32'(din_ready), 32'd0);
        chk("reset_dout_valid", 32'(dout_valid), 32'd0);
        chk("reset_dout", dout, 32'd0);
        chk("reset_nl_req", 32'(nl_req), 32'd0);
        chk("reset_timeout_err", 32'(timeout_err), 32'd0);
        rst = 1'b1;
        #1;
        chk("din_ready_just_released", 32'(din_ready), 32'd0);
        @(negedge clk);
        chk("din_ready_after_clear", 32'(din_ready), 32'd1);

        // Delay, feedback halving and pointer wrap.
        byp_sample(32'h8000_0000, 32'h8000_0000, 2'd0);
        byp_sample(32'h0000_0000, 32'h0000_0000, 2'd1);
        byp_sample(32'h0000_0000, 32'h0000_0000, 2'd2);
        byp_sample(32'h0000_0000, 32'h0000_0000, 2'd3);
        byp_sample(32'h0000_0000, 32'h4000_0000, 2'd0);

        // Load 0xFFF0_0000 into slot 1, then saturate against it.
        byp_sample(32'hFFF0_0000, 32'hFFF0_0000, 2'd1);
        byp_sample(32'h0000_0000, 32'h0000_0000, 2'd2);
        byp_sample(32'h0000_0000, 32'h0000_0000, 2'd3);
        byp_sample(32'h0000_0000, 32'h2000_0000, 2'd0);
        byp_sample(32'hFFFF_FFFF, 32'hFFF0_0000, 2'd1);
        // Low bits are truncated by the 12-bit nonlinearity.
        byp_sample(32'h1234_5678, 32'h1230_0000, 2'd2);

        // External path: ack after 7 waiting cycles.
        ext_sample(32'h1230_0000, 12'h123, 8, 12'hABC, 32'hABC0_0000, 2'd3, 1'b0);
        // No ack: timeout with fb = 0x2000_0000 >> 1.
        ext_sample(32'h0000_0000, 12'h100, 0, 12'h000, 32'h0000_0000, 2'd0, 1'b1);
        // Ack in the expiry cycle wins; fb = 0xFFF0_0000 >> 1.
        ext_sample(32'h0000_0000, 12'h7FF, 16, 12'h5A5, 32'h5A50_0000, 2'd1, 1'b0);

        // Reset in the middle of a request; fb = 0x1230_0000 >> 1.
        accept(32'h1000_0000, 1'b0);
        bypass = 1'b1;
        n = 0;
        @(negedge clk);
        while (nl_req !== 1'b1 && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk("abort_nl_req_rise", 32'(nl_req), 32'd1);
        chk("abort_nl_data_out", 32'(nl_data_out), 32'h191);
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("rst_drops_nl_req", 32'(nl_req), 32'd0);
        chk("rst_nl_data_out", 32'(nl_data_out), 32'd0);
        chk("rst_dout", dout, 32'd0);
        chk("rst_node_idx", 32'(node_idx), 32'd0);
        chk("rst_din_ready", 32'(din_ready), 32'd0);
        @(negedge clk);
        nl_ack     = 1'b1;
        nl_data_in = 12'h777;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        nl_ack = 1'b0;
        chk("post_rst_nl_req", 32'(nl_req), 32'd0);
        chk("post_rst_din_ready", 32'(din_ready), 32'd1);

        // Feedback must come from the cleared buffer, not the pre-reset contents.
        byp_sample(32'h0300_0000, 32'h0300_0000, 2'd0);
        byp_sample(32'h0300_0000, 32'h0300_0000, 2'd1);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
